// File: rtl/tx_commit_sequencer_if.sv
// Allocation, completion and drain signals between the DMA read engine (master)
// and tx_commit_sequencer (slave); rd_addr_in is already in the write clock domain.
interface tx_commit_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 6,
  parameter int TAG_W  = 3
);
  logic [ADDR_W-1:0] rd_addr_in;
  logic              alloc_req;
  logic [LEN_W-1:0]  alloc_len;
  logic              alloc_gnt;
  logic [TAG_W-1:0]  alloc_tag;
  logic [ADDR_W-1:0] alloc_addr;
  logic              cpl_valid;
  logic [TAG_W-1:0]  cpl_tag;
  logic              drain_req;
  logic              drain_done;
  logic [TAG_W:0]    outstanding;
  logic [ADDR_W-1:0] commited_wr_addr;
  logic              err_cpl;
  logic              err_len;

  modport master (
    output rd_addr_in, alloc_req, alloc_len, cpl_valid, cpl_tag, drain_req,
    input  alloc_gnt, alloc_tag, alloc_addr, drain_done, outstanding,
           commited_wr_addr, err_cpl, err_len
  );

  modport slave (
    input  rd_addr_in, alloc_req, alloc_len, cpl_valid, cpl_tag, drain_req,
    output alloc_gnt, alloc_tag, alloc_addr, drain_done, outstanding,
           commited_wr_addr, err_cpl, err_len
  );
endinterface

// File: rtl/tx_commit_sequencer.sv
// Hands out tagged TX-buffer regions, collects out-of-order completions and retires them in order.
// Grant is combinational; commit moves one edge after the oldest slot is done; refused requests must hold.
module tx_commit_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 6,
  parameter int TAG_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tx_commit_sequencer_if.slave  bus
);
  localparam int DEPTH = 1 << TAG_W;

  typedef enum logic {S_RUN, S_DRAIN} state_e;

  state_e            state_q;
  logic              drain_done_q;
  logic [TAG_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [TAG_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] commit_q, commit_d;
  logic [TAG_W:0]    outstanding_q, outstanding_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [ADDR_W-1:0] end_q [DEPTH];
  logic [ADDR_W-1:0] end_d [DEPTH];
  logic              err_cpl_q, err_cpl_d;
  logic              err_len_q, err_len_d;

  logic [ADDR_W-1:0] free;
  logic [ADDR_W-1:0] len_ext;
  logic              room;
  logic              gnt;
  logic              retire;
  logic              cpl_ok;

  // One location is kept empty so that next_addr == rd_addr_in always means empty.
  assign len_ext = ADDR_W'(bus.alloc_len);
  assign free    = bus.rd_addr_in - next_addr_q - ADDR_W'(1);
  // outstanding never exceeds DEPTH, so its MSB alone flags a full table.
  assign room    = ~outstanding_q[TAG_W];
  assign gnt     = bus.alloc_req & (state_q == S_RUN) & (bus.alloc_len != '0) & room
                   & (free >= len_ext);
  assign retire  = valid_q[rd_ptr_q] & done_q[rd_ptr_q];
  assign cpl_ok  = valid_q[bus.cpl_tag] & ~done_q[bus.cpl_tag];

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    next_addr_d   = next_addr_q;
    commit_d      = commit_q;
    valid_d       = valid_q;
    done_d        = done_q;
    end_d         = end_q;
    outstanding_d = outstanding_q;
    err_cpl_d     = bus.cpl_valid & ~cpl_ok;
    err_len_d     = bus.alloc_req & (bus.alloc_len == '0);

    if (retire) begin
      valid_d[rd_ptr_q] = 1'b0;
      done_d[rd_ptr_q]  = 1'b0;
      commit_d          = end_q[rd_ptr_q];
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end

    if (bus.cpl_valid && cpl_ok) begin
      done_d[bus.cpl_tag] = 1'b1;
    end

    // A grant can never target rd_ptr while that slot is live: the table would be full.
    if (gnt) begin
      valid_d[wr_ptr_q] = 1'b1;
      done_d[wr_ptr_q]  = 1'b0;
      end_d[wr_ptr_q]   = next_addr_q + len_ext;
      next_addr_d       = next_addr_q + len_ext;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end

    case ({gnt, retire})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      next_addr_q   <= '0;
      commit_q      <= '0;
      valid_q       <= '0;
      done_q        <= '0;
      outstanding_q <= '0;
      err_cpl_q     <= 1'b0;
      err_len_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) end_q[i] <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      next_addr_q   <= next_addr_d;
      commit_q      <= commit_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      outstanding_q <= outstanding_d;
      err_cpl_q     <= err_cpl_d;
      err_len_q     <= err_len_d;
      for (int i = 0; i < DEPTH; i++) end_q[i] <= end_d[i];
    end
  end

  // drain_done tracks the post-edge count so it rises on the same edge the last slot retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RUN;
      drain_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (bus.drain_req) begin
            state_q      <= S_DRAIN;
            drain_done_q <= (outstanding_d == '0);
          end else begin
            drain_done_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!bus.drain_req) begin
            state_q      <= S_RUN;
            drain_done_q <= 1'b0;
          end else begin
            drain_done_q <= (outstanding_d == '0);
          end
        end
        default: begin
          state_q      <= S_RUN;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alloc_gnt        = gnt;
  assign bus.alloc_tag        = wr_ptr_q;
  assign bus.alloc_addr       = next_addr_q;
  assign bus.drain_done       = drain_done_q;
  assign bus.outstanding      = outstanding_q;
  assign bus.commited_wr_addr = commit_q;
  assign bus.err_cpl          = err_cpl_q;
  assign bus.err_len          = err_len_q;
endmodule

// File: tb/tb_tx_commit_sequencer.sv
// Directed vectors, corner sequences and random traffic against a queue-based model of the sequencer.
module tb_tx_commit_sequencer;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 6;
  localparam int TAG_W  = 3;
  localparam int DEPTH  = 1 << TAG_W;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic clk;
  logic reset_n;

  tx_commit_sequencer_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TAG_W(TAG_W)) bus ();

  tx_commit_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: outstanding regions in allocation order.
  typedef struct {
    int tag;
    int end_a;
    bit done;
  } ent_t;

  ent_t mq[$];
  int   m_next, m_wtag, m_commit, m_rd;
  bit   m_drain;

  typedef struct {
    bit req; int len; bit cv; int ct; bit drain;
    bit e_gnt; int e_tag; int e_addr;
    int e_out; int e_commit; bit e_errc; bit e_errl; bit e_dd;
  } vec_t;

  vec_t tv [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_next = 0; m_wtag = 0; m_commit = 0; m_drain = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.alloc_req = 0; bus.alloc_len = '0; bus.cpl_valid = 0; bus.cpl_tag = '0;
    bus.drain_req = 0; bus.rd_addr_in = '0;
    m_rd = 0;
    #1;
    chk("rst_outstanding", bus.outstanding, 0);
    chk("rst_commit", bus.commited_wr_addr, 0);
    chk("rst_drain_done", bus.drain_done, 0);
    chk("rst_err_cpl", bus.err_cpl, 0);
    chk("rst_err_len", bus.err_len, 0);
    chk("rst_gnt", bus.alloc_gnt, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  // One clock: drive at negedge, check grant, advance model, check registered outputs after the edge.
  task automatic cycle(input bit req, input int len, input bit cv, input int ct, input bit drain,
                       input int rd, output bit g, output int gt, output int ga);
    int  free;
    bit  exp_g, retire, cpl_ok, exp_errc, exp_errl;
    @(negedge clk);
    bus.alloc_req  = req;
    bus.alloc_len  = len[LEN_W-1:0];
    bus.cpl_valid  = cv;
    bus.cpl_tag    = ct[TAG_W-1:0];
    bus.drain_req  = drain;
    bus.rd_addr_in = rd[ADDR_W-1:0];
    #1;
    free  = (rd - m_next - 1) & AMASK;
    exp_g = req && !m_drain && len != 0 && mq.size() < DEPTH && free >= len;
    g  = bus.alloc_gnt;
    gt = int'(bus.alloc_tag);
    ga = int'(bus.alloc_addr);
    chk("alloc_gnt", g, exp_g);
    if (exp_g && g) begin
      chk("alloc_tag", gt, m_wtag);
      chk("alloc_addr", ga, m_next);
    end

    retire = mq.size() > 0 && mq[0].done;
    cpl_ok = 0;
    if (cv) foreach (mq[i]) if (mq[i].tag == ct && !mq[i].done) cpl_ok = 1;
    exp_errc = cv && !cpl_ok;
    exp_errl = req && len == 0;
    if (retire) begin
      m_commit = mq[0].end_a;
      void'(mq.pop_front());
    end
    if (cpl_ok) foreach (mq[i]) if (mq[i].tag == ct) mq[i].done = 1;
    if (exp_g) begin
      mq.push_back('{tag: m_wtag, end_a: (m_next + len) & AMASK, done: 0});
      m_next = (m_next + len) & AMASK;
      m_wtag = (m_wtag + 1) % DEPTH;
    end
    m_drain = drain;

    @(posedge clk);
    #1;
    chk("outstanding", bus.outstanding, mq.size());
    chk("commit", bus.commited_wr_addr, m_commit);
    chk("err_cpl", bus.err_cpl, exp_errc);
    chk("err_len", bus.err_len, exp_errl);
    chk("drain_done", bus.drain_done, m_drain && mq.size() == 0);
  endtask

  task automatic drain_all();
    bit g; int gt, ga;
    for (int k = 0; k < 200 && mq.size() > 0; k++) begin
      int pick;
      pick = -1;
      foreach (mq[i]) if (!mq[i].done && pick < 0) pick = mq[i].tag;
      if (pick >= 0) cycle(0, 1, 1, pick, 0, m_rd, g, gt, ga);
      else           cycle(0, 1, 0, 0, 0, m_rd, g, gt, ga);
    end
    chk("drain_all_outstanding", bus.outstanding, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g; int gt, ga;
    bit req, cv, drq;
    int len, ct;

    reset_n = 1'b0;
    bus.alloc_req = 0; bus.alloc_len = '0; bus.cpl_valid = 0; bus.cpl_tag = '0;
    bus.drain_req = 0; bus.rd_addr_in = '0;

    //       req len cv ct dr  gnt tag addr  out commit errc errl dd
    tv[0]  = '{1, 4, 0, 0, 0,  1, 0, 0,    1, 0,  0, 0, 0};
    tv[1]  = '{1, 8, 0, 0, 0,  1, 1, 4,    2, 0,  0, 0, 0};
    tv[2]  = '{0, 0, 1, 1, 0,  0, 0, 0,    2, 0,  0, 0, 0};
    tv[3]  = '{0, 0, 1, 0, 0,  0, 0, 0,    2, 0,  0, 0, 0};
    tv[4]  = '{0, 0, 0, 0, 0,  0, 0, 0,    1, 4,  0, 0, 0};
    tv[5]  = '{0, 0, 0, 0, 0,  0, 0, 0,    0, 12, 0, 0, 0};
    tv[6]  = '{0, 0, 1, 1, 0,  0, 0, 0,    0, 12, 1, 0, 0};
    tv[7]  = '{0, 0, 0, 0, 0,  0, 0, 0,    0, 12, 0, 0, 0};
    tv[8]  = '{1, 0, 0, 0, 0,  0, 0, 0,    0, 12, 0, 1, 0};
    tv[9]  = '{1, 3, 0, 0, 0,  1, 2, 12,   1, 12, 0, 0, 0};
    tv[10] = '{0, 0, 1, 2, 0,  0, 0, 0,    1, 12, 0, 0, 0};
    tv[11] = '{0, 0, 1, 2, 0,  0, 0, 0,    0, 15, 1, 0, 0};
    tv[12] = '{1, 2, 0, 0, 0,  1, 3, 15,   1, 15, 0, 0, 0};
    tv[13] = '{1, 2, 0, 0, 0,  1, 4, 17,   2, 15, 0, 0, 0};
    tv[14] = '{0, 0, 0, 0, 1,  0, 0, 0,    2, 15, 0, 0, 0};
    tv[15] = '{1, 2, 0, 0, 1,  0, 0, 0,    2, 15, 0, 0, 0};
    tv[16] = '{0, 0, 1, 3, 1,  0, 0, 0,    2, 15, 0, 0, 0};
    tv[17] = '{0, 0, 1, 4, 1,  0, 0, 0,    1, 17, 0, 0, 0};
    tv[18] = '{0, 0, 0, 0, 1,  0, 0, 0,    0, 19, 0, 0, 1};
    tv[19] = '{0, 0, 0, 0, 1,  0, 0, 0,    0, 19, 0, 0, 1};
    tv[20] = '{1, 1, 0, 0, 0,  0, 0, 0,    0, 19, 0, 0, 0};
    tv[21] = '{1, 1, 0, 0, 0,  1, 5, 19,   1, 19, 0, 0, 0};

    do_reset();

    foreach (tv[i]) begin
      cycle(tv[i].req, tv[i].len, tv[i].cv, tv[i].ct, tv[i].drain, 0, g, gt, ga);
      chk($sformatf("tv%0d_gnt", i), g, tv[i].e_gnt);
      if (tv[i].e_gnt) begin
        chk($sformatf("tv%0d_tag", i), gt, tv[i].e_tag);
        chk($sformatf("tv%0d_addr", i), ga, tv[i].e_addr);
      end
      chk($sformatf("tv%0d_out", i), bus.outstanding, tv[i].e_out);
      chk($sformatf("tv%0d_commit", i), bus.commited_wr_addr, tv[i].e_commit);
      chk($sformatf("tv%0d_errc", i), bus.err_cpl, tv[i].e_errc);
      chk($sformatf("tv%0d_errl", i), bus.err_len, tv[i].e_errl);
      chk($sformatf("tv%0d_dd", i), bus.drain_done, tv[i].e_dd);
    end

    // Reset with a tag still in flight discards it and zeroes the commit pointer.
    do_reset();

    // Full table: ninth request refused until the oldest retires.
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, 0, 0, m_rd, g, gt, ga);
    cycle(1, 1, 0, 0, 0, m_rd, g, gt, ga);
    chk("full_refuse", g, 0);
    cycle(1, 1, 1, 0, 0, m_rd, g, gt, ga);
    chk("full_refuse_cpl", g, 0);
    cycle(1, 1, 0, 0, 0, m_rd, g, gt, ga);
    chk("full_refuse_retire_edge", g, 0);
    cycle(1, 1, 0, 0, 0, m_rd, g, gt, ga);
    chk("full_regrant", g, 1);
    chk("full_regrant_tag", gt, 0);
    drain_all();

    // Free space exactly 4 qwords.
    m_rd = (m_next + 5) & AMASK;
    cycle(1, 5, 0, 0, 0, m_rd, g, gt, ga);
    chk("free4_len5", g, 0);
    cycle(1, 4, 0, 0, 0, m_rd, g, gt, ga);
    chk("free4_len4", g, 1);
    drain_all();

    // Walk next_addr to 1020, then allocate across the wrap.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1, 60, 0, 0, 0, m_rd, g, gt, ga);
      cycle(0, 1, 1, gt, 0, m_rd, g, gt, ga);
      cycle(0, 1, 0, 0, 0, m_rd, g, gt, ga);
      m_rd = m_commit;
    end
    m_rd = 100;
    cycle(1, 8, 0, 0, 0, m_rd, g, gt, ga);
    chk("wrap_gnt", g, 1);
    chk("wrap_addr", ga, 1020);
    cycle(0, 1, 1, gt, 0, m_rd, g, gt, ga);
    cycle(0, 1, 0, 0, 0, m_rd, g, gt, ga);
    chk("wrap_commit", bus.commited_wr_addr, 4);

    // Random traffic against the model.
    drq = 0;
    for (int n = 0; n < 1500; n++) begin
      req = ($urandom % 3) != 0;
      len = ($urandom % 16 == 0) ? 0 : int'($urandom_range(1, 63));
      cv  = $urandom % 2;
      if (mq.size() > 0 && ($urandom % 4) != 0) ct = mq[$urandom % mq.size()].tag;
      else ct = $urandom % DEPTH;
      if ($urandom % 64 == 0) drq = !drq;
      if ($urandom % 4 == 0) m_rd = m_commit;
      cycle(req, len, cv, ct, drq, m_rd, g, gt, ga);
    end
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
